// File: rtl/divider_requester_if.sv
// Core-side request/response and divider-side start/result signals of the divide requester.
// The master modport is the requester; the slave modport is the core plus divider around it.
interface divider_requester_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            flush;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic            div_en;
    logic [XLEN-1:0] div_a;
    logic [XLEN-1:0] div_b;
    logic            div_is_signed;
    logic            div_ready;
    logic [XLEN-1:0] div_q;
    logic [XLEN-1:0] div_r;

    modport master (
        input  req_valid, req_funct3, req_a, req_b, flush, div_ready, div_q, div_r,
        output req_ready, result_valid, result, div_en, div_a, div_b, div_is_signed
    );

    modport slave (
        output req_valid, req_funct3, req_a, req_b, flush, div_ready, div_q, div_r,
        input  req_ready, result_valid, result, div_en, div_a, div_b, div_is_signed
    );
endinterface

// File: rtl/divider_requester.sv
// Execute-stage DIV/DIVU/REM/REMU initiator: special cases and last-result hits return 1 cycle after accept,
// otherwise 36 cycles via the divider; one op in flight, req_ready low outside IDLE.
module divider_requester #(
    parameter bit CACHE_EN = 1'b1,
    parameter int XLEN     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    divider_requester_if.master   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    logic [XLEN-1:0] op_a, op_b, res_q, res_r;
    logic            op_signed, op_rem, saw_busy, drop;
    logic            cache_valid, cache_signed;
    logic [XLEN-1:0] cache_a, cache_b, cache_q, cache_r;

    logic accept, in_signed, b_zero, ovf, hit, dropping;

    assign accept    = bus.req_valid && (state == IDLE) && !bus.flush;
    assign in_signed = !bus.req_funct3[0];
    assign b_zero    = (bus.req_b == '0);
    assign ovf       = in_signed && (bus.req_a == MIN_INT) && (bus.req_b == '1);
    assign hit       = CACHE_EN && cache_valid && (bus.req_a == cache_a) &&
                       (bus.req_b == cache_b) && (in_signed == cache_signed);
    assign dropping  = drop || bus.flush;

    assign bus.req_ready     = (state == IDLE);
    assign bus.div_en        = (state == ISSUE) && bus.div_ready && !bus.flush;
    assign bus.div_a         = op_a;
    assign bus.div_b         = op_b;
    assign bus.div_is_signed = op_signed;
    assign bus.result_valid  = (state == RESP) && !bus.flush;
    assign bus.result        = op_rem ? res_r : res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_a         <= '0;
            op_b         <= '0;
            op_signed    <= 1'b0;
            op_rem       <= 1'b0;
            res_q        <= '0;
            res_r        <= '0;
            saw_busy     <= 1'b0;
            drop         <= 1'b0;
            cache_valid  <= 1'b0;
            cache_signed <= 1'b0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_q      <= '0;
            cache_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a      <= bus.req_a;
                        op_b      <= bus.req_b;
                        op_signed <= in_signed;
                        op_rem    <= bus.req_funct3[1];
                        drop      <= 1'b0;
                        if (b_zero) begin
                            res_q <= '1;
                            res_r <= bus.req_a;
                            state <= RESP;
                        end else if (ovf) begin
                            res_q <= MIN_INT;
                            res_r <= '0;
                            state <= RESP;
                        end else if (hit) begin
                            res_q <= cache_q;
                            res_r <= cache_r;
                            state <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (bus.div_ready) begin
                        saw_busy <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.flush) drop <= 1'b1;
                    if (!bus.div_ready) begin
                        saw_busy <= 1'b1;
                    end else if (!saw_busy) begin
                        // Start landed in the divider's done cycle and was ignored; nothing runs for
                        // this op, so a killed op simply leaves.
                        state <= dropping ? IDLE : ISSUE;
                    end else begin
                        cache_valid  <= 1'b1;
                        cache_a      <= op_a;
                        cache_b      <= op_b;
                        cache_signed <= op_signed;
                        cache_q      <= bus.div_q;
                        cache_r      <= bus.div_r;
                        res_q        <= bus.div_q;
                        res_r        <= bus.div_r;
                        state        <= dropping ? IDLE : RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
